mmio_timer: RTL and testbench

MMIO_TIMER -- requirements
Module: mmio_timer

---
 rtl/mmio_timer_pkg.sv | 36 +++
 rtl/mmio_timer_prescaler.sv | 27 ++
 rtl/mmio_timer.sv | 121 ++++++++++++
 tb/tb_mmio_timer.sv | 373 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_timer_pkg.sv
// Shared constants for the memory-mapped machine timer: register map, CTRL fields, reset values.
package mmio_timer_pkg;

    localparam int unsigned DATA_W     = 32;
    localparam int unsigned ADDR_W     = 8;
    localparam int unsigned STRB_W     = 4;
    localparam int unsigned TIME_W     = 64;
    localparam int unsigned PRESCALE_W = 16;

    localparam logic [ADDR_W-1:0] IDX_MTIME_LO    = 8'd0;
    localparam logic [ADDR_W-1:0] IDX_MTIME_HI    = 8'd1;
    localparam logic [ADDR_W-1:0] IDX_MTIMECMP_LO = 8'd2;
    localparam logic [ADDR_W-1:0] IDX_MTIMECMP_HI = 8'd3;
    localparam logic [ADDR_W-1:0] IDX_CTRL        = 8'd4;
    localparam logic [ADDR_W-1:0] IDX_PRESCALE    = 8'd5;

    localparam int unsigned CTRL_ENABLE_BIT = 0;
    localparam int unsigned CTRL_IRQ_EN_BIT = 1;

    localparam logic [TIME_W-1:0]     MTIME_RESET    = 64'h0000_0000_0000_0000;
    localparam logic [TIME_W-1:0]     MTIMECMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic                  CTRL_RESET     = 1'b0;
    localparam logic [PRESCALE_W-1:0] PRESCALE_RESET = 16'h0000;

    // Byte-lane merge used by every writable 32-bit register.
    function automatic logic [DATA_W-1:0] merge_bytes(input logic [DATA_W-1:0] old_word,
                                                      input logic [DATA_W-1:0] new_word,
                                                      input logic [STRB_W-1:0] mask);
        logic [DATA_W-1:0] result;
        for (int unsigned i = 0; i < STRB_W; i++) begin
            result[8*i +: 8] = mask[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
        end
        return result;
    endfunction

endpackage

// File: rtl/mmio_timer_prescaler.sv
// Tick generator: one tick every prescale+1 enabled cycles (used when TIMER_PRESCALER_EN is defined).
module mmio_timer_prescaler
    import mmio_timer_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  load,
    output logic                  tick
);

    logic [PRESCALE_W-1:0] count;

    assign tick = enable && (count == prescale);

    always_ff @(posedge clk) begin
        if (rst || !enable || load) begin
            count <= '0;
        end else if (count == prescale) begin
            count <= '0;
        end else begin
            count <= count + PRESCALE_W'(1);
        end
    end

endmodule

// File: rtl/mmio_timer.sv
// Memory-mapped 64-bit machine timer with compare interrupt.
// Optional prescaler enabled by defining TIMER_PRESCALER_EN.
module mmio_timer
    import mmio_timer_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              request,
    input  logic              we_re,
    input  logic [STRB_W-1:0] masking,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] w_data,
    output logic              valid,
    output logic [DATA_W-1:0] r_data,
    output logic              irq
);

    logic [TIME_W-1:0] mtime, mtime_nxt;
    logic [TIME_W-1:0] mtimecmp, mtimecmp_nxt;
    logic              ctrl_enable, ctrl_enable_nxt;
    logic              ctrl_irq_en, ctrl_irq_en_nxt;
    logic              wr_c, rd_c, tick_c;
    logic [DATA_W-1:0] rd_data_c;

    assign wr_c = request & we_re;
    assign rd_c = request & ~we_re;

`ifdef TIMER_PRESCALER_EN
    logic [PRESCALE_W-1:0] prescale, prescale_nxt;
    logic                  prescale_load_c;

    assign prescale_load_c = wr_c && (address == IDX_PRESCALE);

    mmio_timer_prescaler u_prescaler (
        .clk      (clk),
        .rst      (rst),
        .enable   (ctrl_enable),
        .prescale (prescale),
        .load     (prescale_load_c),
        .tick     (tick_c)
    );

    always_comb begin
        prescale_nxt = prescale;
        if (prescale_load_c) begin
            prescale_nxt = {masking[1] ? w_data[15:8] : prescale[15:8],
                            masking[0] ? w_data[7:0]  : prescale[7:0]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) prescale <= PRESCALE_RESET;
        else     prescale <= prescale_nxt;
    end
`else
    assign tick_c = ctrl_enable;
`endif

    // Read mux over pre-update register values.
    always_comb begin
        rd_data_c = '0;
        case (address)
            IDX_MTIME_LO:    rd_data_c = mtime[31:0];
            IDX_MTIME_HI:    rd_data_c = mtime[63:32];
            IDX_MTIMECMP_LO: rd_data_c = mtimecmp[31:0];
            IDX_MTIMECMP_HI: rd_data_c = mtimecmp[63:32];
            IDX_CTRL:        rd_data_c = {30'd0, ctrl_irq_en, ctrl_enable};
`ifdef TIMER_PRESCALER_EN
            IDX_PRESCALE:    rd_data_c = {16'd0, prescale};
`endif
            default:         rd_data_c = '0;
        endcase
    end

    // Register updates; a write to either mtime half overrides that cycle's tick.
    always_comb begin
        mtime_nxt       = mtime;
        mtimecmp_nxt    = mtimecmp;
        ctrl_enable_nxt = ctrl_enable;
        ctrl_irq_en_nxt = ctrl_irq_en;
        if (tick_c) begin
            mtime_nxt = mtime + TIME_W'(1);
        end
        if (wr_c) begin
            case (address)
                IDX_MTIME_LO:    mtime_nxt = {mtime[63:32], merge_bytes(mtime[31:0], w_data, masking)};
                IDX_MTIME_HI:    mtime_nxt = {merge_bytes(mtime[63:32], w_data, masking), mtime[31:0]};
                IDX_MTIMECMP_LO: mtimecmp_nxt[31:0]  = merge_bytes(mtimecmp[31:0], w_data, masking);
                IDX_MTIMECMP_HI: mtimecmp_nxt[63:32] = merge_bytes(mtimecmp[63:32], w_data, masking);
                IDX_CTRL: begin
                    if (masking[0]) begin
                        ctrl_enable_nxt = w_data[CTRL_ENABLE_BIT];
                        ctrl_irq_en_nxt = w_data[CTRL_IRQ_EN_BIT];
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mtime       <= MTIME_RESET;
            mtimecmp    <= MTIMECMP_RESET;
            ctrl_enable <= CTRL_RESET;
            ctrl_irq_en <= CTRL_RESET;
            valid       <= 1'b0;
            r_data      <= '0;
            irq         <= 1'b0;
        end else begin
            mtime       <= mtime_nxt;
            mtimecmp    <= mtimecmp_nxt;
            ctrl_enable <= ctrl_enable_nxt;
            ctrl_irq_en <= ctrl_irq_en_nxt;
            valid       <= request;
            if (rd_c) r_data <= rd_data_c;
            irq         <= ctrl_irq_en_nxt && (mtime_nxt >= mtimecmp_nxt);
        end
    end

endmodule

// File: tb/tb_mmio_timer.sv
// Self-checking bench for mmio_timer: directed scenarios plus randomized traffic against a reference model.
module tb_mmio_timer;

    logic        clk = 1'b0;
    logic        rst;
    logic        request;
    logic        we_re;
    logic [3:0]  masking;
    logic [7:0]  address;
    logic [31:0] w_data;
    logic        valid;
    logic [31:0] r_data;
    logic        irq;

    int checks = 0;
    int errors = 0;

    // Reference model state.
    logic [63:0] m_mtime, m_cmp;
    logic        m_en, m_irq_en, m_valid, m_irq;
    logic [31:0] m_rdata;
    logic [15:0] m_pre, m_cnt;

    mmio_timer dut (
        .clk     (clk),
        .rst     (rst),
        .request (request),
        .we_re   (we_re),
        .masking (masking),
        .address (address),
        .w_data  (w_data),
        .valid   (valid),
        .r_data  (r_data),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model_merge(input logic [31:0] o, input logic [31:0] n,
                                                input logic [3:0] m);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = m[i] ? n[8*i +: 8] : o[8*i +: 8];
        return r;
    endfunction

    function automatic logic [31:0] model_read(input logic [7:0] a);
        case (a)
            8'd0: return m_mtime[31:0];
            8'd1: return m_mtime[63:32];
            8'd2: return m_cmp[31:0];
            8'd3: return m_cmp[63:32];
            8'd4: return {30'd0, m_irq_en, m_en};
`ifdef TIMER_PRESCALER_EN
            8'd5: return {16'd0, m_pre};
`endif
            default: return 32'd0;
        endcase
    endfunction

    // Advance the model by one clock edge using the currently driven inputs.
    task automatic model_edge();
        logic        tick, wr, load;
        logic [63:0] nt;
        logic [31:0] lo, hi;
        if (rst) begin
            m_mtime = 64'd0; m_cmp = '1; m_en = 0; m_irq_en = 0; m_pre = 0; m_cnt = 0;
            m_valid = 0; m_rdata = 0; m_irq = 0;
            return;
        end
        wr = request && we_re;
        if (request && !we_re) m_rdata = model_read(address);
        m_valid = request;
`ifdef TIMER_PRESCALER_EN
        tick = m_en && (m_cnt == m_pre);
        load = wr && (address == 8'd5);
        if (!m_en || load || m_cnt == m_pre) m_cnt = 0;
        else m_cnt = m_cnt + 16'd1;
        if (load) begin
            lo = model_merge({16'd0, m_pre}, w_data, masking);
            m_pre = lo[15:0];
        end
`else
        tick = m_en;
        load = 1'b0;
`endif
        lo = m_mtime[31:0];
        hi = m_mtime[63:32];
        nt = tick ? m_mtime + 64'd1 : m_mtime;
        if (wr && address == 8'd0) nt = {hi, model_merge(lo, w_data, masking)};
        if (wr && address == 8'd1) nt = {model_merge(hi, w_data, masking), lo};
        if (wr && address == 8'd2) m_cmp = {m_cmp[63:32], model_merge(m_cmp[31:0], w_data, masking)};
        if (wr && address == 8'd3) m_cmp = {model_merge(m_cmp[63:32], w_data, masking), m_cmp[31:0]};
        if (wr && address == 8'd4 && masking[0]) begin
            m_en = w_data[0];
            m_irq_en = w_data[1];
        end
        m_mtime = nt;
        m_irq = m_irq_en && (m_mtime >= m_cmp);
    endtask

    task automatic step(input logic r, input logic w, input logic [3:0] m, input logic [7:0] a,
                        input logic [31:0] d);
        request = r; we_re = w; masking = m; address = a; w_data = d;
        @(posedge clk);
        model_edge();
        #1;
        request = 1'b0;
    endtask

    task automatic wr(input logic [7:0] a, input logic [3:0] m, input logic [31:0] d);
        step(1'b1, 1'b1, m, a, d);
    endtask

    task automatic rd(input logic [7:0] a);
        step(1'b1, 1'b0, 4'h0, a, 32'd0);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 4'h0, 8'd0, 32'd0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle(); idle();
        checks++;
        if (valid !== 1'b0 || r_data !== 32'd0 || irq !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: valid=%b r_data=%h irq=%b expected 0/00000000/0", valid, r_data, irq);
        end
        rst = 1'b0;
        rd(8'd0);
        checks++;
        if (valid !== 1'b1 || r_data !== 32'h0000_0000) begin
            errors++;
            $display("FAIL reset_mtime_lo: valid=%b r_data=%h expected 1/00000000", valid, r_data);
        end
        idle();
        checks++;
        if (valid !== 1'b0) begin
            errors++;
            $display("FAIL valid_single_pulse: valid=%b expected 0", valid);
        end
        rd(8'd3);
        checks++;
        if (r_data !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL reset_mtimecmp_hi: r_data=%h expected ffffffff", r_data);
        end
    endtask

    task automatic test_enable_count();
        wr(8'd4, 4'h1, 32'h1);
        repeat (10) idle();
        rd(8'd0);
        checks++;
        if (r_data !== 32'd10) begin
            errors++;
            $display("FAIL enable_count: r_data=%0d expected 10", r_data);
        end
    endtask

    task automatic test_carry_wrap();
        wr(8'd1, 4'hF, 32'h0);
        wr(8'd0, 4'hF, 32'hFFFF_FFFE);
        idle();
        wr(8'd4, 4'h1, 32'h0);
        rd(8'd1);
        checks++;
        if (r_data !== 32'd1) begin
            errors++;
            $display("FAIL carry_hi: r_data=%h expected 00000001", r_data);
        end
        rd(8'd0);
        checks++;
        if (r_data !== 32'd0) begin
            errors++;
            $display("FAIL carry_lo: r_data=%h expected 00000000", r_data);
        end
        wr(8'd1, 4'hF, 32'hFFFF_FFFF);
        wr(8'd0, 4'hF, 32'hFFFF_FFFF);
        wr(8'd4, 4'h1, 32'h1);
        wr(8'd4, 4'h1, 32'h0);
        rd(8'd1);
        checks++;
        if (r_data !== 32'd0) begin
            errors++;
            $display("FAIL wrap_hi: r_data=%h expected 00000000", r_data);
        end
        rd(8'd0);
        checks++;
        if (r_data !== 32'd0) begin
            errors++;
            $display("FAIL wrap_lo: r_data=%h expected 00000000", r_data);
        end
    endtask

    task automatic test_irq();
        wr(8'd0, 4'hF, 32'd0);
        wr(8'd1, 4'hF, 32'd0);
        wr(8'd2, 4'hF, 32'd20);
        wr(8'd3, 4'hF, 32'd0);
        wr(8'd4, 4'h1, 32'h3);
        for (int k = 1; k <= 20; k++) begin
            idle();
            checks++;
            if (irq !== (k >= 20)) begin
                errors++;
                $display("FAIL irq_rise: cycle=%0d irq=%b expected %b", k, irq, (k >= 20));
            end
        end
        wr(8'd2, 4'hF, 32'hFFFF_FFFF);
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL irq_clear: irq=%b expected 0", irq);
        end
        wr(8'd4, 4'h1, 32'h0);
    endtask

    task automatic test_mask_unmapped();
        logic [31:0] junk;
        wr(8'd0, 4'hF, 32'h1122_3344);
        wr(8'd1, 4'hF, 32'h0);
        wr(8'd4, 4'h1, 32'h1);
        wr(8'd0, 4'b0010, 32'h0000_AB00);
        wr(8'd4, 4'h1, 32'h0);
        rd(8'd0);
        checks++;
        if (r_data !== 32'h1122_AB45) begin
            errors++;
            $display("FAIL mask_collide: r_data=%h expected 1122ab45", r_data);
        end
        junk = $urandom;
        wr(8'd200, 4'hF, junk);
        checks++;
        if (valid !== 1'b1 || r_data !== 32'h1122_AB45) begin
            errors++;
            $display("FAIL unmapped_write: valid=%b r_data=%h expected 1/1122ab45", valid, r_data);
        end
        rd(8'd200);
        checks++;
        if (r_data !== 32'd0) begin
            errors++;
            $display("FAIL unmapped_read: r_data=%h expected 00000000", r_data);
        end
        rd(8'd0);
        checks++;
        if (r_data !== 32'h1122_AB45) begin
            errors++;
            $display("FAIL unmapped_no_change: r_data=%h expected 1122ab45", r_data);
        end
        wr(8'd0, 4'h0, 32'hDEAD_BEEF);
        rd(8'd0);
        checks++;
        if (r_data !== 32'h1122_AB45) begin
            errors++;
            $display("FAIL mask_zero: r_data=%h expected 1122ab45", r_data);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] seq [4] = '{8'd2, 8'd3, 8'd4, 8'd0};
        for (int i = 0; i < 4; i++) begin
            rd(seq[i]);
            checks++;
            if (valid !== 1'b1 || r_data !== m_rdata) begin
                errors++;
                $display("FAIL back_to_back[%0d]: valid=%b r_data=%h expected 1/%h", i, valid, r_data, m_rdata);
            end
        end
    endtask

`ifdef TIMER_PRESCALER_EN
    task automatic test_prescale();
        wr(8'd5, 4'h3, 32'd3);
        wr(8'd0, 4'hF, 32'd0);
        wr(8'd1, 4'hF, 32'd0);
        wr(8'd4, 4'h1, 32'h1);
        repeat (16) idle();
        rd(8'd0);
        checks++;
        if (r_data !== 32'd4) begin
            errors++;
            $display("FAIL prescale_rate: r_data=%0d expected 4", r_data);
        end
        wr(8'd4, 4'h1, 32'h0);
        wr(8'd5, 4'h3, 32'd0);
    endtask
`else
    task automatic test_prescale();
        wr(8'd5, 4'hF, 32'h0000_FFFF);
        rd(8'd5);
        checks++;
        if (r_data !== 32'd0) begin
            errors++;
            $display("FAIL index5_unmapped: r_data=%h expected 00000000", r_data);
        end
    endtask
`endif

    task automatic test_reset_pending();
        logic [31:0] expv [6] = '{32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0};
        wr(8'd4, 4'h1, 32'h3);
        wr(8'd2, 4'hF, 32'h0);
        rd(8'd2);
        rst = 1'b1;
        step(1'b1, 1'b0, 4'h0, 8'd3, 32'd0);
        checks++;
        if (valid !== 1'b0 || r_data !== 32'd0 || irq !== 1'b0) begin
            errors++;
            $display("FAIL reset_pending: valid=%b r_data=%h irq=%b expected 0/00000000/0", valid, r_data, irq);
        end
        step(1'b1, 1'b1, 4'hF, 8'd0, 32'h1234_5678);
        rst = 1'b0;
        idle();
        checks++;
        if (valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_request_ignored: valid=%b expected 0", valid);
        end
        for (int i = 0; i < 6; i++) begin
            rd(8'(i));
            checks++;
            if (r_data !== expv[i]) begin
                errors++;
                $display("FAIL reset_reg[%0d]: r_data=%h expected %h", i, r_data, expv[i]);
            end
        end
    endtask

    task automatic test_random();
        logic        r, w;
        logic [3:0]  m;
        logic [7:0]  a;
        logic [31:0] d;
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(0, 99) == 0);
            r = ($urandom_range(0, 3) != 0);
            w = $urandom_range(0, 1) == 1;
            m = 4'($urandom);
            a = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 6));
            d = $urandom;
            if (a == 8'd5) d = d & 32'h0000_0007;
            if (a <= 8'd1 && $urandom_range(0, 1) == 1) d = d & 32'h0000_00FF;
            step(r, w, m, a, d);
            checks++;
            if (valid !== m_valid || r_data !== m_rdata || irq !== m_irq) begin
                errors++;
                $display("FAIL random[%0d]: valid=%b r_data=%h irq=%b expected %b/%h/%b",
                         i, valid, r_data, irq, m_valid, m_rdata, m_irq);
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; request = 1'b0; we_re = 1'b0; masking = 4'h0; address = 8'd0; w_data = 32'd0;
        m_mtime = 0; m_cmp = '1; m_en = 0; m_irq_en = 0; m_valid = 0; m_irq = 0;
        m_rdata = 0; m_pre = 0; m_cnt = 0;
        test_reset();
        test_enable_count();
        test_carry_wrap();
        test_irq();
        test_mask_unmapped();
        test_back_to_back();
        test_prescale();
        test_reset_pending();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
